stage_ex_mc: RTL and testbench

- Parametrised execute stage with valid/stall/flush pipeline control.
- Adds an iterative multi-cycle multiply/divide unit (MUL, DIVU, REMU) beside the single-cycle ALU.
- Sits between decode and memory stages. Back-pressures decode with o_ready while a multi-cycle op runs.
- Computes the branch target and registers all results into the EX/MEM pipeline register.

---
 rtl/stage_ex_mc.sv | 268 ++++++++++++++++++++++++++
 tb/tb_stage_ex_mc.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_ex_mc.sv
// Execute stage: single-cycle ALU plus an iterative MUL/DIVU/REMU unit, feeding the EX/MEM register.
// Define STAGE_EX_MC_RADIX4_EN to retire two multiply/divide bits per cycle instead of one.
module stage_ex_mc #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_valid,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic [DATA_WIDTH-1:0]     i_dataA,
  input  logic [DATA_WIDTH-1:0]     i_dataB,
  input  logic [DATA_WIDTH-1:0]     i_imm,
  input  logic [ADDR_WIDTH-1:0]     i_pc,
  input  logic [3:0]                i_AluControl,
  input  logic                      i_AluSrcB,
  input  logic [1:0]                i_md_op,
  input  logic                      i_reg_we,
  input  logic                      i_mem_we,
  input  logic                      i_MemToReg,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd,
  input  logic                      i_is_branch,
  input  logic                      i_is_jump,
  output logic                      o_ready,
  output logic                      o_valid,
  output logic [DATA_WIDTH-1:0]     o_AluOut,
  output logic                      o_is_zero,
  output logic [DATA_WIDTH-1:0]     o_WriteData,
  output logic                      o_reg_we,
  output logic                      o_MemWrEnable,
  output logic                      o_MemToReg,
  output logic [REG_ADDR_WIDTH-1:0] o_WriteReg,
  output logic [ADDR_WIDTH-1:0]     o_pc_branch,
  output logic                      o_is_branch,
  output logic                      o_is_jump
);

  localparam int unsigned ShW  = $clog2(DATA_WIDTH);
  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned ExtW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
`ifdef STAGE_EX_MC_RADIX4_EN
  localparam int unsigned Iters = DATA_WIDTH / 2;
`else
  localparam int unsigned Iters = DATA_WIDTH;
`endif
  localparam logic [CntW-1:0] LastCnt = CntW'(Iters - 1);

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluSll  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluSlt  = 4'd8;
  localparam logic [3:0] AluSltu = 4'd9;

  localparam logic [1:0] MdMul  = 2'b01;
  localparam logic [1:0] MdDivu = 2'b10;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     op_b, alu_res, md_res;
  logic [ShW-1:0]            shamt;
  logic [ExtW-1:0]           pc_sum;
  logic [ADDR_WIDTH-1:0]     pc_target;
  logic                      is_md, is_mul, capture, load_alu, load_md, hold;

  logic [1:0]                md_op_q;
  logic [CntW-1:0]           cnt_q;
  logic [DATA_WIDTH-1:0]     acc_q, a_q, b_q, acc_n, a_n, b_n;
  logic [3*DATA_WIDTH-1:0]   step;

  logic [DATA_WIDTH-1:0]     cap_wdata_q;
  logic                      cap_reg_we_q, cap_mem_we_q, cap_m2r_q, cap_br_q, cap_jmp_q;
  logic [REG_ADDR_WIDTH-1:0] cap_rd_q;
  logic [ADDR_WIDTH-1:0]     cap_pc_q;

  logic                      valid_q, zero_q, reg_we_q, mem_we_q, m2r_q, br_q, jmp_q;
  logic [DATA_WIDTH-1:0]     alu_out_q, wdata_q;
  logic [REG_ADDR_WIDTH-1:0] wreg_q;
  logic [ADDR_WIDTH-1:0]     pc_br_q;

  // One radix-2 step. MUL: acc += a if b[0]; a <<= 1; b >>= 1.
  // DIV: acc is the partial remainder, a shifts the dividend out and the quotient in, b is the divisor.
  function automatic logic [3*DATA_WIDTH-1:0] md_step(input logic                  mul,
                                                      input logic [DATA_WIDTH-1:0] acc,
                                                      input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0]   rem;
    logic [DATA_WIDTH-1:0] acc_o, a_o, b_o;
    rem = {acc, a[DATA_WIDTH-1]};
    a_o = a << 1;
    if (mul) begin
      acc_o = b[0] ? acc + a : acc;
      b_o   = b >> 1;
    end else begin
      b_o = b;
      if (rem >= {1'b0, b}) begin
        rem    = rem - {1'b0, b};
        a_o[0] = 1'b1;
      end
      acc_o = rem[DATA_WIDTH-1:0];
    end
    return {acc_o, a_o, b_o};
  endfunction

  always_comb begin
    op_b    = i_AluSrcB ? i_imm : i_dataB;
    shamt   = op_b[ShW-1:0];
    alu_res = '0;
    case (i_AluControl)
      AluAdd:  alu_res = i_dataA + op_b;
      AluSub:  alu_res = i_dataA - op_b;
      AluAnd:  alu_res = i_dataA & op_b;
      AluOr:   alu_res = i_dataA | op_b;
      AluXor:  alu_res = i_dataA ^ op_b;
      AluSll:  alu_res = i_dataA << shamt;
      AluSrl:  alu_res = i_dataA >> shamt;
      AluSra:  alu_res = $unsigned($signed(i_dataA) >>> shamt);
      AluSlt:  alu_res = DATA_WIDTH'($signed(i_dataA) < $signed(op_b));
      AluSltu: alu_res = DATA_WIDTH'(i_dataA < op_b);
      default: alu_res = '0;
    endcase
    pc_sum    = ExtW'(i_pc) + ExtW'($signed(i_imm));
    pc_target = pc_sum[ADDR_WIDTH-1:0];
  end

  always_comb begin
    is_mul = (md_op_q == MdMul);
    step   = md_step(is_mul, acc_q, a_q, b_q);
`ifdef STAGE_EX_MC_RADIX4_EN
    step   = md_step(is_mul, step[3*DATA_WIDTH-1:2*DATA_WIDTH], step[2*DATA_WIDTH-1:DATA_WIDTH],
                     step[DATA_WIDTH-1:0]);
`endif
    acc_n  = step[3*DATA_WIDTH-1:2*DATA_WIDTH];
    a_n    = step[2*DATA_WIDTH-1:DATA_WIDTH];
    b_n    = step[DATA_WIDTH-1:0];
    md_res = (md_op_q == MdDivu) ? a_q : acc_q;
  end

  always_comb begin
    is_md    = i_valid && (i_md_op != 2'b00);
    capture  = (state_q == StIdle) && is_md && !i_flush;
    load_alu = (state_q == StIdle) && i_valid && (i_md_op == 2'b00) && !i_stall && !i_flush;
    load_md  = (state_q == StDone) && !i_stall && !i_flush;
    hold     = i_stall && !i_flush;
    o_ready  = !i_Reset && (i_flush ||
               (!i_stall && (((state_q == StIdle) && !is_md) || (state_q == StDone))));

    state_d = state_q;
    if (i_flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (is_md) state_d = StCalc;
        StCalc:  if (cnt_q == LastCnt) state_d = StDone;
        StDone:  if (!i_stall) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= StIdle;
      md_op_q      <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cap_wdata_q  <= '0;
      cap_reg_we_q <= 1'b0;
      cap_mem_we_q <= 1'b0;
      cap_m2r_q    <= 1'b0;
      cap_rd_q     <= '0;
      cap_pc_q     <= '0;
      cap_br_q     <= 1'b0;
      cap_jmp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        md_op_q      <= i_md_op;
        cnt_q        <= '0;
        acc_q        <= '0;
        a_q          <= i_dataA;
        b_q          <= op_b;
        cap_wdata_q  <= i_dataB;
        cap_reg_we_q <= i_reg_we;
        cap_mem_we_q <= i_mem_we;
        cap_m2r_q    <= i_MemToReg;
        cap_rd_q     <= i_rd;
        cap_pc_q     <= pc_target;
        cap_br_q     <= i_is_branch;
        cap_jmp_q    <= i_is_jump;
      end else if (state_q == StCalc) begin
        cnt_q <= cnt_q + 1'b1;
        acc_q <= acc_n;
        a_q   <= a_n;
        b_q   <= b_n;
      end
    end
  end

  // EX/MEM register: load, hold on stall, otherwise insert a bubble.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      valid_q   <= 1'b0;
      alu_out_q <= '0;
      zero_q    <= 1'b0;
      wdata_q   <= '0;
      reg_we_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      m2r_q     <= 1'b0;
      wreg_q    <= '0;
      pc_br_q   <= '0;
      br_q      <= 1'b0;
      jmp_q     <= 1'b0;
    end else if (load_alu) begin
      valid_q   <= 1'b1;
      alu_out_q <= alu_res;
      zero_q    <= (alu_res == '0);
      wdata_q   <= i_dataB;
      reg_we_q  <= i_reg_we;
      mem_we_q  <= i_mem_we;
      m2r_q     <= i_MemToReg;
      wreg_q    <= i_rd;
      pc_br_q   <= pc_target;
      br_q      <= i_is_branch;
      jmp_q     <= i_is_jump;
    end else if (load_md) begin
      valid_q   <= 1'b1;
      alu_out_q <= md_res;
      zero_q    <= (md_res == '0);
      wdata_q   <= cap_wdata_q;
      reg_we_q  <= cap_reg_we_q;
      mem_we_q  <= cap_mem_we_q;
      m2r_q     <= cap_m2r_q;
      wreg_q    <= cap_rd_q;
      pc_br_q   <= cap_pc_q;
      br_q      <= cap_br_q;
      jmp_q     <= cap_jmp_q;
    end else if (!hold) begin
      valid_q  <= 1'b0;
      reg_we_q <= 1'b0;
      mem_we_q <= 1'b0;
      br_q     <= 1'b0;
      jmp_q    <= 1'b0;
    end
  end

  assign o_valid       = valid_q;
  assign o_AluOut      = alu_out_q;
  assign o_is_zero     = zero_q;
  assign o_WriteData   = wdata_q;
  assign o_reg_we      = reg_we_q;
  assign o_MemWrEnable = mem_we_q;
  assign o_MemToReg    = m2r_q;
  assign o_WriteReg    = wreg_q;
  assign o_pc_branch   = pc_br_q;
  assign o_is_branch   = br_q;
  assign o_is_jump     = jmp_q;

endmodule

// File: tb/tb_stage_ex_mc.sv
// Scoreboard bench for stage_ex_mc: directed corner cases plus randomized ALU/MD traffic with stalls.
module tb_stage_ex_mc;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;
`ifdef STAGE_EX_MC_RADIX4_EN
  localparam int Iters = DW / 2;
`else
  localparam int Iters = DW;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, valid, stall, flush, alu_src_b, reg_we, mem_we, mem_to_reg, is_branch, is_jump;
  logic [DW-1:0] data_a, data_b, imm;
  logic [AW-1:0] pc;
  logic [3:0]    alu_ctrl;
  logic [1:0]    md_op;
  logic [RW-1:0] rd;
  logic          ready, out_valid, is_zero, out_reg_we, mem_wr_en, out_mem_to_reg;
  logic          out_is_branch, out_is_jump;
  logic [DW-1:0] alu_out, write_data;
  logic [RW-1:0] write_reg;
  logic [AW-1:0] pc_branch;
  logic [107:0]  all_out;

  assign all_out = {out_valid, alu_out, is_zero, write_data, out_reg_we, mem_wr_en, out_mem_to_reg,
                    write_reg, pc_branch, out_is_branch, out_is_jump};

  stage_ex_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_dataA(data_a), .i_dataB(data_b), .i_imm(imm), .i_pc(pc), .i_AluControl(alu_ctrl),
    .i_AluSrcB(alu_src_b), .i_md_op(md_op), .i_reg_we(reg_we), .i_mem_we(mem_we),
    .i_MemToReg(mem_to_reg), .i_rd(rd), .i_is_branch(is_branch), .i_is_jump(is_jump),
    .o_ready(ready), .o_valid(out_valid), .o_AluOut(alu_out), .o_is_zero(is_zero),
    .o_WriteData(write_data), .o_reg_we(out_reg_we), .o_MemWrEnable(mem_wr_en),
    .o_MemToReg(out_mem_to_reg), .o_WriteReg(write_reg), .o_pc_branch(pc_branch),
    .o_is_branch(out_is_branch), .o_is_jump(out_is_jump)
  );

  typedef struct packed {
    logic [1:0]    md;
    logic [3:0]    op;
    logic [DW-1:0] a, b, imm;
    logic [AW-1:0] pc;
    logic          srcb;
    logic [RW-1:0] rd;
    logic          rwe, mwe, m2r, br, jmp;
  } instr_t;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic          zero;
    logic [DW-1:0] wdata;
    logic          rwe, mwe, m2r;
    logic [RW-1:0] rd;
    logic [AW-1:0] pc;
    logic          br, jmp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: ops 0..9 = add sub and or xor sll srl sra slt sltu; md 1 mul, 2 divu, 3 remu.
  function automatic logic [DW-1:0] ref_result(input logic [1:0] md, input logic [3:0] op,
                                               input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    case (md)
      2'd1: r = a * b;
      2'd2: r = (b == 0) ? '1 : a / b;
      2'd3: r = (b == 0) ? a : a % b;
      default: begin
        case (op)
          4'd0: r = a + b;
          4'd1: r = a - b;
          4'd2: r = a & b;
          4'd3: r = a | b;
          4'd4: r = a ^ b;
          4'd5: r = a << b[4:0];
          4'd6: r = a >> b[4:0];
          4'd7: r = $signed(a) >>> b[4:0];
          4'd8: r = ($signed(a) < $signed(b)) ? 1 : 0;
          4'd9: r = (a < b) ? 1 : 0;
          default: r = '0;
        endcase
      end
    endcase
    return r;
  endfunction

  function automatic instr_t mk(input logic [1:0] md, input logic [3:0] op,
                                input logic [DW-1:0] a, input logic [DW-1:0] b);
    instr_t in;
    in = '0;
    in.md = md; in.op = op; in.a = a; in.b = b;
    in.imm = 32'h10; in.pc = 32'h100; in.rd = 5'd3; in.rwe = 1'b1;
    return in;
  endfunction

  function automatic instr_t rand_instr();
    instr_t in;
    in.md   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    in.op   = 4'($urandom_range(0, 9));
    in.a    = $urandom;
    case ($urandom_range(0, 7))
      0:       in.b = '0;
      1:       in.b = in.a;
      2, 3:    in.b = DW'($urandom_range(1, 40));
      default: in.b = $urandom;
    endcase
    in.imm  = ($urandom_range(0, 1) == 0) ? DW'($signed(12'($urandom))) : DW'($urandom_range(0, 9));
    in.pc   = $urandom;
    in.srcb = 1'($urandom);
    in.rd   = RW'($urandom);
    in.rwe  = 1'($urandom);
    in.mwe  = 1'($urandom);
    in.m2r  = 1'($urandom);
    in.br   = 1'($urandom);
    in.jmp  = 1'($urandom);
    return in;
  endfunction

  task automatic drive(input instr_t in);
    valid = 1'b1;  md_op = in.md;  alu_ctrl = in.op;  data_a = in.a;  data_b = in.b;
    imm = in.imm;  pc = in.pc;  alu_src_b = in.srcb;  rd = in.rd;  reg_we = in.rwe;
    mem_we = in.mwe;  mem_to_reg = in.m2r;  is_branch = in.br;  is_jump = in.jmp;
  endtask

  task automatic push_exp(input instr_t in);
    exp_t e;
    e.alu   = ref_result(in.md, in.op, in.a, in.srcb ? in.imm : in.b);
    e.zero  = (e.alu == 0);
    e.wdata = in.b;  e.rwe = in.rwe;  e.mwe = in.mwe;  e.m2r = in.m2r;  e.rd = in.rd;
    e.pc    = in.pc + in.imm;  e.br = in.br;  e.jmp = in.jmp;
    sb.push_back(e);
  endtask

  // Presents one instruction and returns just after the edge that consumes it.
  task automatic send(input instr_t in, input bit rnd_stall, output int waits);
    @(negedge clk);
    drive(in);
    flush = 1'b0;
    stall = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
    #1;
    waits = 0;
    while (!ready && waits < 200) begin
      @(negedge clk);
      stall = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      #1;
      waits++;
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_ready required=ready");
      valid = 1'b0;
    end else begin
      push_exp(in);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'b0;
      flush = 1'b0;
      stall = 1'($urandom);
    end
  endtask

  // Monitor: every unstalled edge that leaves a valid EX/MEM entry is a new result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && !stall && !flush && out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0h required=none", alu_out);
        end else begin
          e = sb.pop_front();
          chk("result", alu_out, e.alu);
          chk("is_zero", is_zero, e.zero);
          chk("sideband", {write_data, out_reg_we, mem_wr_en, out_mem_to_reg, write_reg, pc_branch,
                           out_is_branch, out_is_jump},
              {e.wdata, e.rwe, e.mwe, e.m2r, e.rd, e.pc, e.br, e.jmp});
        end
      end
    end
  end

  initial begin
    int w;
    instr_t in;
    rst = 1'b1;  stall = 1'b0;  flush = 1'b1;
    drive(mk(2'd1, 4'd0, 32'd3, 32'd4));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_ready", ready, 0);
    chk("reset_outputs", all_out, 0);
    rst = 1'b0;  flush = 1'b0;  valid = 1'b0;

    send(mk(2'd0, 4'd0, 32'd5, 32'd7), 0, w);
    chk("add_wait", w, 0);
    #1;
    chk("add_valid", out_valid, 1);
    chk("add_out", alu_out, 32'd12);
    chk("add_zero", is_zero, 0);

    send(mk(2'd1, 4'd0, 32'h0001_0003, 32'h5), 0, w);
    chk("mul_busy_cycles", w, Iters + 1);
    #1;
    chk("mul_valid", out_valid, 1);
    chk("mul_out", alu_out, 32'h0005_000F);

    send(mk(2'd2, 4'd0, 32'd100, 32'd7), 0, w);
    send(mk(2'd3, 4'd0, 32'd100, 32'd7), 0, w);
    send(mk(2'd2, 4'd0, 32'd13, 32'd0), 0, w);
    send(mk(2'd3, 4'd0, 32'd13, 32'd0), 0, w);

    // Stall while the result waits in DONE.
    @(negedge clk);
    in = mk(2'd1, 4'd0, 32'd7, 32'd9);
    drive(in);
    stall = 1'b0;
    repeat (Iters + 1) @(negedge clk);
    stall = 1'b1;
    #1;
    chk("done_stall_ready", ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("done_stall_hold", {out_valid, out_reg_we}, 0);
      @(negedge clk);
      #1;
      if (i < 2) chk("done_stall_ready_hold", ready, 0);
    end
    stall = 1'b0;
    #1;
    chk("done_release_ready", ready, 1);
    push_exp(in);
    @(posedge clk);

    // Flush kills a presented ALU op, even with stall asserted.
    @(negedge clk);
    drive(mk(2'd0, 4'd0, 32'd3, 32'd4));
    flush = 1'b1;
    stall = 1'b1;
    #1;
    chk("flush_alu_ready", ready, 1);
    @(posedge clk);
    #1;
    chk("flush_alu_outputs", {out_valid, out_reg_we, mem_wr_en}, 0);

    // Flush during DIVU CALC, then an ADD must go straight through.
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    drive(mk(2'd2, 4'd0, 32'd1000, 32'd3));
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_calc_ready", ready, 1);
    @(posedge clk);
    #1;
    chk("flush_calc_outputs", {out_valid, out_reg_we}, 0);
    send(mk(2'd0, 4'd0, 32'd1, 32'd1), 0, w);
    chk("post_flush_wait", w, 0);
    #1;
    chk("post_flush_add", alu_out, 32'd2);

    // Flush in DONE discards the result.
    @(negedge clk);
    drive(mk(2'd1, 4'd0, 32'd6, 32'd6));
    stall = 1'b1;
    repeat (Iters + 1) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_done_valid", out_valid, 0);
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    valid = 1'b0;
    @(posedge clk);
    #1;
    chk("flush_done_discarded", out_valid, 0);

    // Reset in the middle of CALC.
    in = mk(2'd0, 4'd0, 32'h1234, 32'h1);
    in.br = 1'b1;
    send(in, 0, w);
    @(negedge clk);
    drive(mk(2'd1, 4'd0, 32'd11, 32'd13));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_midcalc_ready", ready, 0);
    @(posedge clk);
    #1;
    chk("reset_midcalc_outputs", all_out, 0);
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
    send(mk(2'd1, 4'd0, 32'd6, 32'd7), 0, w);
    chk("post_reset_mul_cycles", w, Iters + 1);

    for (int n = 0; n < 80; n++) begin
      send(rand_instr(), 1, w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    @(negedge clk);
    valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
